// File: rtl/common_lib_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : common_lib_rr_arb_mux
// Function : Round-robin arbiter sharing one valid/ready channel between
//            N_REQ requesters. Locks onto a requester until its in_last beat,
//            selects data through a one-hot AND-OR mux and registers the
//            result in a single output slot.
// Revision : 1.0 - initial release
// ============================================================================
module common_lib_rr_arb_mux #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        a_rst,
  input  logic [N_REQ-1:0]            in_vld,
  output logic [N_REQ-1:0]            in_rdy,
  input  logic [N_REQ-1:0][WIDTH-1:0] in_data,
  input  logic [N_REQ-1:0]            in_last,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
  output logic [N_REQ-1:0]            out_sel_1h
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [N_REQ-1:0] lock_1h;
  logic [N_REQ-1:0] lock_1h_nxt;

  logic [N_REQ-1:0] grant_arb;
  logic [N_REQ-1:0] grant_1h;
  logic [PTR_W-1:0] grant_idx;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             found;
  int               scan_idx;

  // Rotating-priority scan starting just after the last completed requester
  always_comb begin
    grant_arb = '0;
    found     = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (i == scan_idx) && in_vld[i]) begin
          grant_arb[i] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  // Grant source, output-slot availability and handshake; in_rdy is held low
  // during reset so no requester sees a transfer that will be discarded
  always_comb begin
    grant_1h  = (state == LOCK) ? (lock_1h & in_vld) : grant_arb;
    slot_free = ~out_vld | out_rdy;
    in_rdy    = grant_1h & {N_REQ{slot_free & ~a_rst}};
    accept    = |(in_vld & in_rdy);
  end

  // One-hot AND-OR data/last select and binary index of the winner
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | (in_data[i] & {WIDTH{grant_1h[i]}});
      sel_last = sel_last | (in_last[i] & grant_1h[i]);
      if (grant_1h[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end

  // Next-state: a last beat closes the packet and moves the pointer,
  // any other beat locks the arbiter onto its requester
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_1h_nxt = lock_1h;
    if (accept) begin
      if (sel_last) begin
        rr_ptr_nxt = grant_idx;
        state_nxt  = ARB;
      end else begin
        lock_1h_nxt = grant_1h;
        state_nxt   = LOCK;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state   <= ARB;
      rr_ptr  <= PTR_W'(N_REQ - 1);
      lock_1h <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_1h <= lock_1h_nxt;
    end
  end

  // Output slot: load on accept (replacing a draining beat without a
  // bubble), empty on drain, hold everything under backpressure
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_sel_1h <= '0;
    end else if (accept) begin
      out_vld    <= 1'b1;
      out_data   <= sel_data;
      out_last   <= sel_last;
      out_sel_1h <= grant_1h;
    end else if (out_rdy) begin
      out_vld    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_common_lib_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_common_lib_rr_arb_mux
// Function : Scoreboard bench for the round-robin arbiter/mux. A reference
//            model predicts grants and output occupancy; accepted beats are
//            queued and a monitor compares them against the output register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_common_lib_rr_arb_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int W1 = 32;

  logic clk   = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [N-1:0]        in_vld, in_rdy, in_last, out_sel_1h;
  logic [N-1:0][W-1:0] in_data;
  logic                out_vld, out_rdy, out_last;
  logic [W-1:0]        out_data;

  // single-requester instance
  logic [0:0]          in_vld1, in_rdy1, in_last1, out_sel1;
  logic [0:0][W1-1:0]  in_data1;
  logic                out_vld1, out_rdy1, out_last1;
  logic [W1-1:0]       out_data1;

  common_lib_rr_arb_mux #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .a_rst(a_rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_last(out_last), .out_sel_1h(out_sel_1h)
  );

  common_lib_rr_arb_mux #(.N_REQ(1), .WIDTH(W1)) dut1 (
    .clk(clk), .a_rst(a_rst),
    .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1), .in_last(in_last1),
    .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1),
    .out_last(out_last1), .out_sel_1h(out_sel1)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [N-1:0] sel;
  } beat_t;

  typedef struct packed {
    logic         gap;
    logic         last;
    logic [W-1:0] data;
  } src_t;

  beat_t        exp_q[$];
  src_t         srcq[N][$];
  logic [N-1:0] off_vld;
  logic [N-1:0] off_last;
  logic [W-1:0] off_data[N];
  int           m_last;
  int           m_lock;
  bit           m_full;
  int           sel_log[$];
  int           data_log[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_at(string name, int k, int es, int ed);
    check({name, "_sel"}, (k < sel_log.size()) ? sel_log[k] : -1, es);
    if (ed >= 0) check({name, "_data"}, (k < data_log.size()) ? data_log[k] : -1, ed);
  endfunction

  // Reference arbitration: locked requester only, else first valid after last winner
  function automatic int model_grant(logic [N-1:0] v);
    int vi = int'(v);
    if (m_lock >= 0) return ((vi >> m_lock) & 1) != 0 ? m_lock : -1;
    for (int k = 1; k <= N; k++) begin
      if (((vi >> ((m_last + k) % N)) & 1) != 0) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic void src_push(int r, bit gap, bit last, int data);
    src_t e;
    e.gap  = gap;
    e.last = last;
    e.data = W'(data);
    srcq[r].push_back(e);
  endfunction

  task automatic do_reset();
    a_rst   = 1'b1;
    in_vld  = '1;
    in_last = '1;
    out_rdy = 1'b1;
    in_vld1 = '0;
    out_rdy1 = 1'b0;
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_sel", out_sel_1h, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    exp_q.delete();
    sel_log.delete();
    data_log.delete();
    for (int i = 0; i < N; i++) srcq[i].delete();
    off_vld  = '0;
    off_last = '0;
    m_full   = 1'b0;
    m_last   = N - 1;
    m_lock   = -1;
    @(posedge clk);
    #1;
    check("rst_hold_out_vld", out_vld, 0);
    check("rst_hold_in_rdy", in_rdy, 0);
    @(negedge clk);
    in_vld = '0;
    a_rst  = 1'b0;
  endtask

  // One clock of stimulus plus model prediction; accepted beats go to the scoreboard
  task automatic step(int p_vld, int p_last, int p_rdy);
    int           g;
    bit           sf;
    bit           acc;
    logic [N-1:0] exp_rdy;
    src_t         e;
    beat_t        b;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!off_vld[i]) begin
        if (srcq[i].size() > 0) begin
          e = srcq[i].pop_front();
          if (!e.gap) begin
            off_vld[i]  = 1'b1;
            off_data[i] = e.data;
            off_last[i] = e.last;
          end
        end else if (int'($urandom_range(99)) < p_vld) begin
          off_vld[i]  = 1'b1;
          off_data[i] = W'($urandom);
          off_last[i] = (int'($urandom_range(99)) < p_last);
        end
      end
    end
    in_vld  = off_vld;
    in_last = off_last;
    for (int i = 0; i < N; i++) in_data[i] = off_data[i];
    out_rdy = (int'($urandom_range(99)) < p_rdy);
    #1;
    g       = model_grant(off_vld);
    sf      = !m_full || out_rdy;
    acc     = (g >= 0) && sf;
    exp_rdy = acc ? N'(1 << g) : '0;
    check("out_vld", out_vld, m_full);
    check("in_rdy", in_rdy, exp_rdy);
    if (acc) begin
      b.data = off_data[g];
      b.last = off_last[g];
      b.sel  = N'(1 << g);
      exp_q.push_back(b);
      if (off_last[g]) begin
        m_last = g;
        m_lock = -1;
      end else begin
        m_lock = g;
      end
      off_vld[g] = 1'b0;
    end
    m_full = acc ? 1'b1 : (out_rdy ? 1'b0 : m_full);
  endtask

  // Monitor: whatever the output slot shows must be the oldest outstanding beat
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!a_rst && out_vld) begin
        if (exp_q.size() == 0) begin
          check("out_vld_with_nothing_queued", out_vld, 0);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_last", out_last, exp_q[0].last);
          check("out_sel_1h", out_sel_1h, exp_q[0].sel);
          if (out_rdy) begin
            sel_log.push_back(int'(out_sel_1h));
            data_log.push_back(int'(out_data));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W1-1:0] words[16];
    bit            lasts[16];
    int            tx;
    int            rx;
    bit            m1_full;
    bit            acc1;

    in_vld = '0; in_last = '0; out_rdy = 1'b0; in_data = '0;
    in_vld1 = '0; in_last1 = '0; out_rdy1 = 1'b0; in_data1 = '0;
    for (int i = 0; i < N; i++) off_data[i] = '0;
    #2;

    // Round-robin order after reset, one beat per cycle
    do_reset();
    repeat (5) step(100, 100, 100);
    repeat (6) step(0, 0, 100);
    check_at("rr", 0, 1, -1);
    check_at("rr", 1, 2, -1);
    check_at("rr", 2, 4, -1);
    check_at("rr", 3, 8, -1);
    check_at("rr", 4, 1, -1);

    // Packet lock: requester 1 three-beat packet, requester 2 waiting
    do_reset();
    src_push(1, 0, 0, 'h11);
    src_push(1, 0, 0, 'h12);
    src_push(1, 0, 1, 'h13);
    src_push(2, 0, 1, 'h22);
    repeat (8) step(0, 0, 100);
    check_at("lock", 0, 2, 'h11);
    check_at("lock", 1, 2, 'h12);
    check_at("lock", 2, 2, 'h13);
    check_at("lock", 3, 4, 'h22);

    // Backpressure on requester 3, then release with no bubble
    do_reset();
    src_push(3, 0, 1, 'hA5);
    src_push(3, 0, 1, 'hB6);
    repeat (5) step(0, 0, 0);
    repeat (4) step(0, 0, 100);
    check_at("bp", 0, 8, 'hA5);
    check_at("bp", 1, 8, 'hB6);

    // Locked but idle requester 0 keeps requester 1 out
    do_reset();
    src_push(0, 0, 0, 'h01);
    src_push(0, 1, 0, 0);
    src_push(0, 1, 0, 0);
    src_push(0, 1, 0, 0);
    src_push(0, 0, 1, 'h02);
    src_push(1, 0, 1, 'h31);
    repeat (10) step(0, 0, 100);
    check_at("idle", 0, 1, 'h01);
    check_at("idle", 1, 1, 'h02);
    check_at("idle", 2, 2, 'h31);

    // Reset in the middle of requester 2's packet with a beat held
    do_reset();
    src_push(2, 0, 0, 'h41);
    src_push(2, 0, 0, 'h42);
    src_push(2, 0, 0, 'h43);
    repeat (2) step(0, 0, 0);
    do_reset();
    step(100, 100, 100);
    repeat (6) step(0, 0, 100);
    check_at("post_rst", 0, 1, -1);

    // Random traffic with backpressure, then full-rate traffic
    do_reset();
    repeat (600) step(60, 40, 70);
    repeat (200) step(80, 50, 100);
    repeat (30) step(0, 0, 100);
    check("scoreboard_drained", exp_q.size(), 0);

    // Single-requester, 32-bit instance: 16 beats with random out_rdy
    do_reset();
    for (int k = 0; k < 16; k++) begin
      words[k] = $urandom;
      lasts[k] = 1'($urandom_range(1));
    end
    tx = 0;
    rx = 0;
    m1_full = 1'b0;
    for (int cyc = 0; cyc < 400 && rx < 16; cyc++) begin
      @(negedge clk);
      in_vld1[0]  = (tx < 16) && ($urandom_range(3) != 0);
      in_data1[0] = words[(tx < 16) ? tx : 15];
      in_last1[0] = lasts[(tx < 16) ? tx : 15];
      out_rdy1    = 1'($urandom_range(1));
      #1;
      acc1 = in_vld1[0] && (!m1_full || out_rdy1);
      check("n1_in_rdy", in_rdy1, acc1);
      check("n1_out_vld", out_vld1, m1_full);
      if (out_vld1 && out_rdy1) begin
        if (rx < 16) begin
          check("n1_data", out_data1, words[rx]);
          check("n1_last", out_last1, lasts[rx]);
          check("n1_sel", out_sel1, 1);
          rx++;
        end else begin
          check("n1_extra_beat", out_vld1, 0);
        end
      end
      if (acc1) tx++;
      m1_full = acc1 ? 1'b1 : (out_rdy1 ? 1'b0 : m1_full);
    end
    check("n1_delivered", rx, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
